// File: rtl/reset_seq_if.sv
// Signal bundle between the reset sequencer and its environment: the three
// reset sources in, the per-channel resets, ready flag and sticky cause out.
interface reset_seq_if #(
  parameter int N_CH = 4
);
  logic            btn_rst_n;
  logic            pll_lock;
  logic            sw_rst;
  logic [N_CH-1:0] rst_out;
  logic            ready;
  logic [2:0]      cause;

  modport master (
    output btn_rst_n, pll_lock, sw_rst,
    input  rst_out, ready, cause
  );

  modport slave (
    input  btn_rst_n, pll_lock, sw_rst,
    output rst_out, ready, cause
  );
endinterface

// File: rtl/reset_seq.sv
// Sequenced multi-channel reset controller: holds all channels in reset until
// the sources are quiet for HOLD_CYC cycles, then releases them one by one.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_ASSERT | all channels in reset, waiting for a fault-free cycle
// S_HOLD   | counting fault-free cycles before the first release
// S_STEP   | releasing channels, one every STEP_CYC cycles
// S_RUN    | all channels released, ready high
module reset_seq #(
  parameter int N_CH     = 4,
  parameter int HOLD_CYC = 1000000,
  parameter int STEP_CYC = 100,
  parameter int SYNC_STG = 2
) (
  input logic         clk_100,
  input logic         rst,
  reset_seq_if.slave  bus
);

  localparam int MAX_CYC = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_HOLD   = 2'd1,
    S_STEP   = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_CH-1:0]     rst_out_q, rst_out_d;
  logic                ready_q, ready_d;
  logic [2:0]          cause_q, cause_d;
  logic [SYNC_STG-1:0] btn_sync_q, btn_sync_d;
  logic [SYNC_STG-1:0] pll_sync_q, pll_sync_d;

  logic btn_sync;
  logic pll_sync;
  logic fault;

  assign btn_sync = btn_sync_q[SYNC_STG-1];
  assign pll_sync = pll_sync_q[SYNC_STG-1];
  assign fault    = ~btn_sync | ~pll_sync | bus.sw_rst;

  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STG-2:0], bus.btn_rst_n};
    pll_sync_d = {pll_sync_q[SYNC_STG-2:0], bus.pll_lock};
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    cause_d    = cause_q;

    if (state_q == S_ASSERT) begin
      if (!fault) begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    end else if (fault) begin
      // Any fault after leaving ASSERT discards all progress and records why.
      state_d   = S_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      cause_d   = {bus.sw_rst, ~pll_sync, ~btn_sync};
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d      = S_STEP;
            cnt_d        = '0;
            idx_d        = '0;
            rst_out_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STEP: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
              for (int i = 1; i < N_CH; i++) begin
                if (i == int'(idx_q) + 1) rst_out_d[i] = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q    <= S_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      cause_q    <= 3'b000;
      btn_sync_q <= '0;
      pll_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      cause_q    <= cause_d;
      btn_sync_q <= btn_sync_d;
      pll_sync_q <= pll_sync_d;
    end
  end

  assign bus.rst_out = rst_out_q;
  assign bus.ready   = ready_q;
  assign bus.cause   = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: directed scenarios followed by random fault traffic,
// every cycle compared against a timeline model of the release schedule.
module tb_reset_seq;

  localparam int N_CH     = 3;
  localparam int HOLD_CYC = 8;
  localparam int STEP_CYC = 4;
  localparam int SYNC_STG = 2;
  localparam int T_DONE   = HOLD_CYC + N_CH * STEP_CYC;

  logic clk_100 = 1'b0;
  logic rst     = 1'b1;

  reset_seq_if #(.N_CH(N_CH)) bus ();

  reset_seq #(
    .N_CH(N_CH), .HOLD_CYC(HOLD_CYC), .STEP_CYC(STEP_CYC), .SYNC_STG(SYNC_STG)
  ) dut (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_100 = ~clk_100;

  int checks   = 0;
  int failures = 0;

  // Model: m_t = edges since the sequencer left reset-assert (-1 while asserted).
  int                  m_t = -1;
  logic [2:0]          m_cause = 3'b000;
  logic [SYNC_STG-1:0] m_btn = '0;
  logic [SYNC_STG-1:0] m_pll = '0;

  task automatic model_reset();
    m_t     = -1;
    m_cause = 3'b000;
    m_btn   = '0;
    m_pll   = '0;
  endtask

  task automatic model_edge();
    logic b, p, f;
    b = m_btn[SYNC_STG-1];
    p = m_pll[SYNC_STG-1];
    f = !b || !p || bus.sw_rst;
    if (m_t < 0) begin
      if (!f) m_t = 0;
    end else if (f) begin
      m_cause = {bus.sw_rst, !p, !b};
      m_t     = -1;
    end else if (m_t < T_DONE) begin
      m_t++;
    end
    m_btn = {m_btn[SYNC_STG-2:0], bus.btn_rst_n};
    m_pll = {m_pll[SYNC_STG-2:0], bus.pll_lock};
  endtask

  task automatic check(string tag);
    logic [N_CH-1:0] e_rst;
    logic            e_rdy;
    for (int i = 0; i < N_CH; i++) e_rst[i] = (m_t < HOLD_CYC + i * STEP_CYC);
    e_rdy = (m_t >= T_DONE);
    checks++;
    assert (bus.rst_out === e_rst) else begin
      failures++;
      $error("FAIL %s rst_out got=%b exp=%b t=%0d", tag, bus.rst_out, e_rst, m_t);
    end
    checks++;
    assert (bus.ready === e_rdy) else begin
      failures++;
      $error("FAIL %s ready got=%b exp=%b t=%0d", tag, bus.ready, e_rdy, m_t);
    end
    checks++;
    assert (bus.cause === m_cause) else begin
      failures++;
      $error("FAIL %s cause got=%b exp=%b", tag, bus.cause, m_cause);
    end
  endtask

  task automatic cyc(string tag);
    @(posedge clk_100);
    model_edge();
    @(negedge clk_100);
    check(tag);
  endtask

  task automatic run(int n, string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic run_until_t(int target, int budget, string tag);
    for (int i = 0; i < budget && m_t != target; i++) cyc(tag);
    checks++;
    assert (m_t == target) else begin
      failures++;
      $error("FAIL %s timeout got_t=%0d exp_t=%0d", tag, m_t, target);
    end
  endtask

  task automatic expect_out(logic [N_CH-1:0] e_rst, logic e_rdy, logic [2:0] e_cause, string tag);
    checks++;
    assert (bus.rst_out === e_rst && bus.ready === e_rdy && bus.cause === e_cause) else begin
      failures++;
      $error("FAIL %s got=%b/%b/%b exp=%b/%b/%b", tag, bus.rst_out, bus.ready, bus.cause,
             e_rst, e_rdy, e_cause);
    end
  endtask

  // Pulses rst between edges and checks the outputs before any clock edge.
  task automatic async_reset(string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check(tag);
    expect_out('1, 1'b0, 3'b000, tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.btn_rst_n = 1'b1;
    bus.pll_lock  = 1'b1;
    bus.sw_rst    = 1'b0;

    // Power-up
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100);
      check("reset_hold");
    end
    rst = 1'b0;
    run(2, "sync_fill");
    expect_out('1, 1'b0, 3'b000, "powerup_sync");
    run_until_t(0, 5, "enter_hold");
    run(HOLD_CYC, "hold");
    expect_out(3'b110, 1'b0, 3'b000, "first_release");
    run(STEP_CYC, "step1");
    expect_out(3'b100, 1'b0, 3'b000, "second_release");
    run(STEP_CYC, "step2");
    expect_out(3'b000, 1'b0, 3'b000, "third_release");
    run(STEP_CYC, "step3");
    expect_out(3'b000, 1'b1, 3'b000, "powerup_ready");

    // Button bounce mid-hold restarts the count
    bus.btn_rst_n = 1'b0;
    cyc("btn_drop");
    bus.btn_rst_n = 1'b1;
    run_until_t(0, 10, "btn_rehold");
    run_until_t(5, 10, "btn_count5");
    bus.btn_rst_n = 1'b0;
    cyc("bounce");
    bus.btn_rst_n = 1'b1;
    run(3, "bounce_sync");
    expect_out('1, 1'b0, 3'b001, "bounce_cause");
    run(T_DONE + 6, "bounce_recover");
    expect_out(3'b000, 1'b1, 3'b001, "bounce_ready");

    // Software reset pulse in RUN
    bus.sw_rst = 1'b1;
    cyc("sw_pulse");
    bus.sw_rst = 1'b0;
    expect_out('1, 1'b0, 3'b100, "sw_assert");
    cyc("sw_rehold");
    run(T_DONE, "sw_reseq");
    expect_out(3'b000, 1'b1, 3'b100, "sw_ready");

    // PLL loss after the first release
    bus.sw_rst = 1'b1;
    cyc("pll_prep");
    bus.sw_rst = 1'b0;
    run_until_t(HOLD_CYC + 1, 30, "pll_step");
    bus.pll_lock = 1'b0;
    run(3, "pll_loss");
    expect_out('1, 1'b0, 3'b010, "pll_cause");
    run(25, "pll_unlocked");
    expect_out('1, 1'b0, 3'b010, "pll_no_release");
    bus.pll_lock = 1'b1;
    run(T_DONE + 4, "pll_relock");
    expect_out(3'b000, 1'b1, 3'b010, "pll_ready");

    // Button and software reset landing on the same edge
    bus.btn_rst_n = 1'b0;
    run(2, "both_sync");
    bus.sw_rst = 1'b1;
    cyc("both_edge");
    bus.sw_rst    = 1'b0;
    bus.btn_rst_n = 1'b1;
    expect_out('1, 1'b0, 3'b101, "both_cause");
    run(T_DONE + 4, "both_recover");

    // Async reset in STEP
    bus.sw_rst = 1'b1;
    cyc("ar_prep");
    bus.sw_rst = 1'b0;
    run_until_t(HOLD_CYC + STEP_CYC + 1, 40, "ar_step");
    async_reset("async_mid_step");
    run(T_DONE + 4, "ar_recover");

    // Random fault traffic
    for (int k = 0; k < 800; k++) begin
      bus.btn_rst_n = ($urandom_range(0, 44) != 0);
      bus.pll_lock  = ($urandom_range(0, 59) != 0);
      bus.sw_rst    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) async_reset("rand_async");
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
